oric_ram_arbiter: RTL and testbench
===================================

Name: oric_ram_arbiter

Overview:
- Sequences the single main-RAM port of the Oric system and shares it between three sources: a post-reset clear sweep, the CPU/ULA bus, and the cassette loader's byte-write stream.
- Sits between oricatmos (ram_* bus), cassettecached (tape_* stream) and the dpram.
- Replaces the dual-port tape path with one arbitrated port; tape writes are buffered in a small FIFO so they never stall the CPU.

Parameters:
AW, 16, RAM address width; the clear sweep covers 0 to 2^AW-1.
FIFO_DEPTH, 4, tape write FIFO entries; must be a power of 2 and at least 2.
FILL_VALUE, 8'hFF, byte written to every location during the clear sweep.

Ports:
clk_48  in  1  system clock; every register is on its rising edge.
reset  in  1  asynchronous, active-high reset.
cpu_cs  in  1  CPU/ULA RAM access request, sampled each cycle.
cpu_we  in  1  1 = write, 0 = read.
cpu_ad  in  AW  CPU address.
cpu_d  in  8  CPU write data.
cpu_q  out  8  read data; combinational copy of mem_do.
cpu_rd_valid  out  1  high the cycle after a granted CPU read.
tape_wr  in  1  push request for one tape byte.
tape_addr  in  AW  tape byte address.
tape_dout  in  8  tape byte.
tape_complete  in  1  level from the loader: last byte has been issued.
tape_full  out  1  FIFO cannot accept a push this cycle.
tape_overflow  out  1  sticky: a push was dropped.
tape_done  out  1  sticky: tape_complete seen and FIFO empty.
clr_busy  out  1  clear sweep in progress.
mem_ce  out  1  RAM port enable.
mem_we  out  1  RAM port write enable.
mem_a  out  AW  RAM port address.
mem_di  out  8  RAM port write data.
mem_do  in  8  RAM read data; registered, 1-cycle latency.

Behaviour:
- Reset values (async, while reset=1): FIFO empty, state CLEAR, clear address 0, clr_busy=1, all mem_* 0, cpu_rd_valid=0, tape_full=0, tape_overflow=0, tape_done=0.
- All mem_* outputs are registered. The RAM sees a grant one cycle after the decision, so read data appears 2 cycles after cpu_cs is sampled.
- State CLEAR:
  - Each cycle drives mem_ce=1, mem_we=1, mem_a=clr_addr, mem_di=FILL_VALUE, then increments clr_addr.
  - After writing address 2^AW-1 the block moves to RUN; clr_busy drops in the same cycle the state changes.
  - cpu_cs is ignored: no grant, cpu_rd_valid stays 0.
  - Tape pushes are accepted into the FIFO but not drained.
- State RUN, priority per cycle:
  - cpu_cs=1: grant CPU. mem_ce=1, mem_we=cpu_we, mem_a=cpu_ad, mem_di=cpu_d.
  - Else FIFO non-empty: pop the head and write it (mem_ce=1, mem_we=1).
  - Else idle: mem_ce=0, mem_we=0.
- CPU wins every collision; the tape FIFO drains only in cycles with no CPU request.
- cpu_rd_valid pulses for one cycle, 2 cycles after the sampled read request, aligned with valid mem_do. CPU writes never raise it.
- FIFO:
  - Entry holds {addr, data}; count is 0..FIFO_DEPTH with pointer wrap modulo FIFO_DEPTH.
  - Push and pop in the same cycle: both happen and the count is unchanged, including when count=FIFO_DEPTH.
  - tape_full = (count==FIFO_DEPTH) && !pop_this_cycle.
  - tape_wr while tape_full=1: the byte is dropped and tape_overflow is set (sticky until reset).
- tape_done:
  - Set when tape_complete=1, count=0 and no push is in progress.
  - Cleared by reset or by any accepted push.
- Reset mid-sweep or mid-drain: FIFO contents are discarded and the sweep restarts at 0.

Optional Feature:
ORIC_RAM_CLEAR_EN
- Defined: CLEAR state and sweep behave as above.
- Undefined: after reset the block enters RUN directly; clr_busy is tied to 0 and no fill writes are issued. RAM contents are whatever the memory model initialises to.

Test Plan:
- Sweep: AW=4, release reset → exactly 16 writes of 8'hFF to addresses 0..15 on consecutive cycles; clr_busy falls after address 15; cpu_cs during the sweep gets no grant.
- CPU read: in RUN, write 8'h5A at 16'h1234 via CPU, then read it → cpu_rd_valid high exactly 2 cycles after the read request with cpu_q=8'h5A.
- Collision: cpu_cs held high 10 cycles while tape pushes 3 bytes → zero tape writes during those cycles; the 3 writes complete in order in the first 3 cycles after cpu_cs drops.
- Overflow: FIFO_DEPTH=4, cpu_cs held high, 5 pushes → tape_full high after the 4th, 5th dropped, tape_overflow=1; after release only 4 writes occur.
- Full push+pop: count=4, cpu_cs low, push in the same cycle → accepted, tape_overflow stays 0.
- Done and reset: tape_complete=1 with 2 queued bytes → tape_done rises only after both are written. Asserting reset mid-sweep at address 7 → mem_* go to 0 immediately, and the sweep restarts at 0 on release.

Source files
------------

// File: rtl/oric_ram_arbiter.sv
// Oric main-RAM port arbiter: clear sweep, CPU/ULA bus, tape write FIFO.
// Optional macro ORIC_RAM_CLEAR_EN enables the post-reset fill sweep.
module oric_ram_arbiter #(
  parameter int          AW         = 16,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [7:0]  FILL_VALUE = 8'hFF
) (
  input  logic          clk_48,
  input  logic          reset,
  input  logic          cpu_cs,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_ad,
  input  logic [7:0]    cpu_d,
  output logic [7:0]    cpu_q,
  output logic          cpu_rd_valid,
  input  logic          tape_wr,
  input  logic [AW-1:0] tape_addr,
  input  logic [7:0]    tape_dout,
  input  logic          tape_complete,
  output logic          tape_full,
  output logic          tape_overflow,
  output logic          tape_done,
  output logic          clr_busy,
  output logic          mem_ce,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [7:0]    mem_di,
  input  logic [7:0]    mem_do
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {
    S_CLEAR,
    S_RUN
  } state_t;

`ifdef ORIC_RAM_CLEAR_EN
  localparam state_t RST_STATE = S_CLEAR;
`else
  localparam state_t RST_STATE = S_RUN;
`endif

  state_t        state;
  logic [AW-1:0] clr_addr;
  logic          rd_pend;

  logic [AW-1:0] fifo_a [FIFO_DEPTH];
  logic [7:0]    fifo_d [FIFO_DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] count;

  logic run;
  logic pop;
  logic push;
  logic empty;

  assign cpu_q     = mem_do;
  assign run       = (state == S_RUN);
  assign empty     = (count == '0);
  assign pop       = run && !cpu_cs && !empty;
  assign tape_full = (count == CW'(FIFO_DEPTH)) && !pop;
  assign push      = tape_wr && !tape_full;

`ifdef ORIC_RAM_CLEAR_EN
  assign clr_busy = (state == S_CLEAR);
`else
  assign clr_busy = 1'b0;
`endif

  // Port sequencer: sweep, then CPU-first arbitration with FIFO drain.
  always_ff @(posedge clk_48 or posedge reset) begin
    if (reset) begin
      state        <= RST_STATE;
      clr_addr     <= '0;
      mem_ce       <= 1'b0;
      mem_we       <= 1'b0;
      mem_a        <= '0;
      mem_di       <= '0;
      rd_pend      <= 1'b0;
      cpu_rd_valid <= 1'b0;
    end else begin
      cpu_rd_valid <= rd_pend;
      rd_pend      <= 1'b0;
      unique case (state)
        S_CLEAR: begin
          mem_ce   <= 1'b1;
          mem_we   <= 1'b1;
          mem_a    <= clr_addr;
          mem_di   <= FILL_VALUE;
          clr_addr <= clr_addr + AW'(1);
          if (clr_addr == {AW{1'b1}})
            state <= S_RUN;
        end
        S_RUN: begin
          if (cpu_cs) begin
            mem_ce  <= 1'b1;
            mem_we  <= cpu_we;
            mem_a   <= cpu_ad;
            mem_di  <= cpu_d;
            rd_pend <= !cpu_we;
          end else if (pop) begin
            mem_ce <= 1'b1;
            mem_we <= 1'b1;
            mem_a  <= fifo_a[rptr];
            mem_di <= fifo_d[rptr];
          end else begin
            mem_ce <= 1'b0;
            mem_we <= 1'b0;
          end
        end
        default: state <= RST_STATE;
      endcase
    end
  end

  // FIFO pointers and occupancy; push and pop may coincide at full.
  always_ff @(posedge clk_48 or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push)
        wptr <= wptr + PW'(1);
      if (pop)
        rptr <= rptr + PW'(1);
      if (push && !pop)
        count <= count + CW'(1);
      else if (pop && !push)
        count <= count - CW'(1);
    end
  end

  // FIFO storage, no reset needed: occupancy gates every read.
  always_ff @(posedge clk_48) begin
    if (push) begin
      fifo_a[wptr] <= tape_addr;
      fifo_d[wptr] <= tape_dout;
    end
  end

  // Sticky tape status flags.
  always_ff @(posedge clk_48 or posedge reset) begin
    if (reset) begin
      tape_overflow <= 1'b0;
      tape_done     <= 1'b0;
    end else begin
      if (tape_wr && tape_full)
        tape_overflow <= 1'b1;
      if (push)
        tape_done <= 1'b0;
      else if (tape_complete && empty)
        tape_done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_oric_ram_arbiter.sv
// Randomised and directed bench for oric_ram_arbiter
// against a cycle-level reference model.
module tb_oric_ram_arbiter;

  localparam int AW    = 4;
  localparam int DEPTH = 4;
  localparam int NLOC  = 2 ** AW;

`ifdef ORIC_RAM_CLEAR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  logic          clk_48 = 1'b0;
  logic          reset;
  logic          cpu_cs;
  logic          cpu_we;
  logic [AW-1:0] cpu_ad;
  logic [7:0]    cpu_d;
  logic [7:0]    cpu_q;
  logic          cpu_rd_valid;
  logic          tape_wr;
  logic [AW-1:0] tape_addr;
  logic [7:0]    tape_dout;
  logic          tape_complete;
  logic          tape_full;
  logic          tape_overflow;
  logic          tape_done;
  logic          clr_busy;
  logic          mem_ce;
  logic          mem_we;
  logic [AW-1:0] mem_a;
  logic [7:0]    mem_di;
  logic [7:0]    mem_do = 8'h00;

  logic [7:0] ram [NLOC] = '{default: 8'h00};

  int compares = 0;
  int fails    = 0;

  // reference model state
  bit            m_run;
  int            m_clr;
  logic [AW-1:0] qa [$];
  logic [7:0]    qd [$];
  logic [7:0]    ref_ram [NLOC] = '{default: 8'h00};
  bit            e_ce, e_we, e_rdv, rd1, ovf, done;
  logic [AW-1:0] e_a;
  logic [7:0]    e_di, e_q, q1;

  oric_ram_arbiter #(
    .AW(AW), .FIFO_DEPTH(DEPTH), .FILL_VALUE(8'hFF)
  ) dut (
    .clk_48(clk_48), .reset(reset),
    .cpu_cs(cpu_cs), .cpu_we(cpu_we),
    .cpu_ad(cpu_ad), .cpu_d(cpu_d),
    .cpu_q(cpu_q), .cpu_rd_valid(cpu_rd_valid),
    .tape_wr(tape_wr), .tape_addr(tape_addr),
    .tape_dout(tape_dout),
    .tape_complete(tape_complete),
    .tape_full(tape_full),
    .tape_overflow(tape_overflow),
    .tape_done(tape_done), .clr_busy(clr_busy),
    .mem_ce(mem_ce), .mem_we(mem_we),
    .mem_a(mem_a), .mem_di(mem_di),
    .mem_do(mem_do)
  );

  always #5 clk_48 = ~clk_48;

  // registered single-port RAM
  always @(posedge clk_48) begin
    if (mem_ce) begin
      if (mem_we) ram[mem_a] <= mem_di;
      else        mem_do <= ram[mem_a];
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    compares++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run = !CLR_EN;
    m_clr = 0;
    qa.delete();
    qd.delete();
    e_ce = 0; e_we = 0; rd1 = 0;
    ovf = 0; done = 0;
  endtask

  task automatic do_reset();
    cpu_cs = 0; cpu_we = 0; cpu_ad = '0; cpu_d = '0;
    tape_wr = 0; tape_addr = '0; tape_dout = '0;
    tape_complete = 0;
    reset = 1'b1;
    #1;
    chk("rst_mem_ce", mem_ce, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_a", mem_a, 0);
    chk("rst_mem_di", mem_di, 0);
    chk("rst_rd_valid", cpu_rd_valid, 0);
    chk("rst_full", tape_full, 0);
    chk("rst_ovf", tape_overflow, 0);
    chk("rst_done", tape_done, 0);
    chk("rst_clr_busy", clr_busy, CLR_EN);
    model_reset();
    @(posedge clk_48);
    @(negedge clk_48);
    reset = 1'b0;
  endtask

  task automatic step(input logic cs, input logic we,
                      input logic [AW-1:0] ad,
                      input logic [7:0] d,
                      input logic twr,
                      input logic [AW-1:0] ta,
                      input logic [7:0] td,
                      input logic tc);
    int n;
    bit pop, full, push;
    cpu_cs = cs; cpu_we = we; cpu_ad = ad; cpu_d = d;
    tape_wr = twr; tape_addr = ta; tape_dout = td;
    tape_complete = tc;
    #1;
    n    = qa.size();
    pop  = m_run && !cs && n != 0;
    full = (n == DEPTH) && !pop;
    push = twr && !full;
    chk("tape_full", tape_full, full);
    e_rdv = rd1;
    e_q   = q1;
    rd1   = 0;
    if (!m_run) begin
      e_ce = 1; e_we = 1;
      e_a = AW'(m_clr); e_di = 8'hFF;
      ref_ram[m_clr] = 8'hFF;
      if (m_clr == NLOC - 1) m_run = 1;
      m_clr++;
    end else if (cs) begin
      e_ce = 1; e_we = we; e_a = ad; e_di = d;
      if (we) ref_ram[ad] = d;
      else begin
        rd1 = 1;
        q1  = ref_ram[ad];
      end
    end else if (pop) begin
      e_ce = 1; e_we = 1;
      e_a = qa.pop_front();
      e_di = qd.pop_front();
      ref_ram[e_a] = e_di;
    end else begin
      e_ce = 0; e_we = 0;
    end
    if (twr && full) ovf = 1;
    if (push) begin
      qa.push_back(ta);
      qd.push_back(td);
      done = 0;
    end else if (tc && n == 0) begin
      done = 1;
    end
    @(posedge clk_48);
    #1;
    chk("mem_ce", mem_ce, e_ce);
    chk("mem_we", mem_we, e_we);
    if (e_ce) begin
      chk("mem_a", mem_a, e_a);
      chk("mem_di", mem_di, e_di);
    end
    chk("clr_busy", clr_busy, !m_run);
    chk("rd_valid", cpu_rd_valid, e_rdv);
    if (e_rdv) chk("cpu_q", cpu_q, e_q);
    chk("overflow", tape_overflow, ovf);
    chk("done", tape_done, done);
    @(negedge clk_48);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++)
      step(0, 0, '0, '0, 0, '0, '0, 0);
  endtask

  task automatic rnd_cs_steps(input int k);
    for (int i = 0; i < k; i++)
      step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           AW'($urandom), 8'($urandom), 0, '0, '0, 0);
  endtask

  initial begin
    @(negedge clk_48);
    do_reset();

    // sweep, interrupted by reset at address 7, then complete
    if (CLR_EN) begin
      rnd_cs_steps(8);
      do_reset();
      rnd_cs_steps(NLOC);
      chk("sweep_end_busy", clr_busy, 0);
    end
    idle(2);

    // CPU write then read back
    step(1, 1, 4'h4, 8'h5A, 0, '0, '0, 0);
    step(1, 0, 4'h4, 8'h00, 0, '0, '0, 0);
    step(0, 0, '0, '0, 0, '0, '0, 0);
    chk("rd5a_valid", cpu_rd_valid, 1);
    chk("rd5a_q", cpu_q, 8'h5A);
    idle(1);
    chk("rd5a_pulse", cpu_rd_valid, 0);

    // collision: CPU holds the port while 3 bytes queue
    for (int i = 0; i < 10; i++)
      step(1, $urandom_range(0, 1) == 1, AW'($urandom),
           8'($urandom), i < 3, AW'(i + 8),
           8'(8'hA0 + i), 0);
    idle(4);

    // overflow: 5 pushes behind a busy CPU
    for (int i = 0; i < 5; i++)
      step(1, 0, AW'($urandom), '0, 1, AW'(i),
           8'(8'hC0 + i), 0);
    chk("ovf_set", tape_overflow, 1);
    idle(6);

    // push while full and popping
    do_reset();
    if (CLR_EN) rnd_cs_steps(NLOC);
    for (int i = 0; i < 4; i++)
      step(1, 1, AW'(i), 8'(i), 1, AW'(i + 4),
           8'(8'h30 + i), 0);
    step(0, 0, '0, '0, 1, 4'hF, 8'h77, 0);
    chk("pushpop_ovf", tape_overflow, 0);
    idle(6);

    // done waits for queued bytes
    for (int i = 0; i < 2; i++)
      step(1, 1, 4'h0, 8'h11, 1, AW'(i + 2),
           8'(8'h90 + i), 1);
    chk("done_early", tape_done, 0);
    for (int i = 0; i < 4; i++)
      step(0, 0, '0, '0, 0, '0, '0, 1);
    chk("done_late", tape_done, 1);

    // random traffic
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 2) == 0,
           $urandom_range(0, 1) == 1,
           AW'($urandom), 8'($urandom),
           $urandom_range(0, 1) == 1,
           AW'($urandom), 8'($urandom),
           $urandom_range(0, 7) == 0);
    idle(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compares, fails);
    $finish;
  end

endmodule
